// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
//   Groups the operand/opcode inputs and the registered result outputs of the
//   4-bit ALU. The clock and reset are not part of the bundle; they stay as
//   plain ports on the ALU.
//
//   Signals
//     A        [3:0]  operand A
//     B        [3:0]  operand B
//     CarryIN         carry/borrow-in, also the bit shifted in by rotates
//     opCodeA  [2:0]  operation select
//     Y        [3:0]  registered result
//     CarryOUT        registered carry-out / shifted-out bit
//     overflow        registered two's-complement overflow flag
//
//   Modports
//     master : the side that drives operands and observes results
//     slave  : the ALU itself
// -----------------------------------------------------------------------------
interface alu_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       CarryIN;
  logic [2:0] opCodeA;
  logic [3:0] Y;
  logic       CarryOUT;
  logic       overflow;

  modport master (
    output A, B, CarryIN, opCodeA,
    input  Y, CarryOUT, overflow
  );

  modport slave (
    input  A, B, CarryIN, opCodeA,
    output Y, CarryOUT, overflow
  );
endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   4-bit registered arithmetic/logic unit. The result, carry and signed
//   overflow are computed combinationally from the operands and registered on
//   every rising clock edge, so each result appears one clock after its
//   operands are sampled. A new operation is accepted every cycle.
//
//   Ports
//     clk   in   rising-edge clock
//     rst   in   asynchronous, active-high reset; clears Y, CarryOUT, overflow
//     bus   slave side of alu_if (A, B, CarryIN, opCodeA in; Y, CarryOUT,
//           overflow out)
//
//   Opcodes
//     000 ADD  {C,R} = A + B + CarryIN
//     001 SUB  {C,R} = A + ~B + CarryIN   (CarryIN=1 gives A-B, C=1 = no borrow)
//     010 AND  011 OR  100 XOR  101 NOT(A)
//     110 RLC  R = {A[2:0],CarryIN}, C = A[3]
//     111 RRC  R = {CarryIN,A[3:1]}, C = A[0]
// -----------------------------------------------------------------------------
module alu (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_RLC = 3'b110,
    OP_RRC = 3'b111
  } op_e;

  op_e        op_s;
  logic [4:0] add_sum_s;
  logic [4:0] sub_sum_s;

  logic [3:0] y_d;
  logic       c_d;
  logic       v_d;

  logic [3:0] y_q;
  logic       c_q;
  logic       v_q;

  assign op_s = op_e'(bus.opCodeA);

  // Subtraction reuses the adder form with B inverted; bit 4 is the carry
  // (1 = no borrow when CarryIN=1).
  assign add_sum_s = {1'b0, bus.A} + {1'b0, bus.B}  + {4'b0000, bus.CarryIN};
  assign sub_sum_s = {1'b0, bus.A} + {1'b0, ~bus.B} + {4'b0000, bus.CarryIN};

  // Next result, carry and overflow for the selected operation.
  always_comb begin
    y_d = 4'b0000;
    c_d = 1'b0;
    v_d = 1'b0;
    case (op_s)
      OP_ADD: begin
        y_d = add_sum_s[3:0];
        c_d = add_sum_s[4];
        // Overflow: like-signed operands producing a differently-signed result.
        v_d = (bus.A[3] == bus.B[3]) & (add_sum_s[3] != bus.A[3]);
      end
      OP_SUB: begin
        y_d = sub_sum_s[3:0];
        c_d = sub_sum_s[4];
        // Overflow: unlike-signed operands and result sign differs from A.
        v_d = (bus.A[3] != bus.B[3]) & (sub_sum_s[3] != bus.A[3]);
      end
      OP_AND: y_d = bus.A & bus.B;
      OP_OR:  y_d = bus.A | bus.B;
      OP_XOR: y_d = bus.A ^ bus.B;
      OP_NOT: y_d = ~bus.A;
      OP_RLC: begin
        y_d = {bus.A[2:0], bus.CarryIN};
        c_d = bus.A[3];
      end
      OP_RRC: begin
        y_d = {bus.CarryIN, bus.A[3:1]};
        c_d = bus.A[0];
      end
      default: begin
        y_d = 4'b0000;
        c_d = 1'b0;
        v_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears them immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= 4'b0000;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign bus.Y        = y_q;
  assign bus.CarryOUT = c_q;
  assign bus.overflow = v_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//   Self-checking bench for the 4-bit registered ALU. An integer-arithmetic
//   reference model predicts each result; a compare process checks the DUT
//   against it on every falling edge, and a table of hand-computed vectors
//   pins both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Packed {C, R[3:0], V}
  logic [5:0] exp_q = 6'b000000;

  function automatic int sgn4(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Reference model: integer arithmetic on the operation's meaning.
  function automatic logic [5:0] model(input int a, input int b, input int cin, input int op);
    int r;
    int c;
    int s;
    int sv;
    int v;
    r = 0; c = 0; v = 0;
    case (op)
      0: begin
        s  = a + b + cin;
        r  = s % 16;
        c  = s / 16;
        sv = sgn4(a) + sgn4(b) + cin;
        v  = (sv > 7 || sv < -8) ? 1 : 0;
      end
      1: begin
        s  = a + (15 - b) + cin;
        r  = s % 16;
        c  = s / 16;
        sv = sgn4(a) - sgn4(b) - 1 + cin;
        v  = (sv > 7 || sv < -8) ? 1 : 0;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: begin
        r = ((a * 2) % 16) + cin;
        c = a / 8;
      end
      7: begin
        r = cin * 8 + a / 2;
        c = a % 2;
      end
      default: r = 0;
    endcase
    return {c[0], r[3:0], v[0]};
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got C=%b Y=%b V=%b, expected C=%b Y=%b V=%b at %0t",
               name, act[5], act[4:1], act[0], req[5], req[4:1], req[0], $time);
    end
  endtask

  // Expected output registers, fed by the model.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= 6'b000000;
    end else begin
      exp_q <= model(int'(bus.A), int'(bus.B), int'(bus.CarryIN), int'(bus.opCodeA));
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    chk("cycle", {bus.CarryOUT, bus.Y, bus.overflow}, rst ? 6'b000000 : exp_q);
  end

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] y;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vecs [15];

  task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic cin);
    bus.opCodeA = op;
    bus.A       = a;
    bus.B       = b;
    bus.CarryIN = cin;
  endtask

  initial begin
    //               op      A      B      Cin    Y      C     V
    vecs[0]  = {3'd0, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[1]  = {3'd0, 4'h7, 4'h7, 1'b1, 4'hF, 1'b0, 1'b1};
    vecs[2]  = {3'd1, 4'h7, 4'hF, 1'b1, 4'h8, 1'b0, 1'b1};
    vecs[3]  = {3'd1, 4'hF, 4'h0, 1'b0, 4'hE, 1'b1, 1'b0};
    vecs[4]  = {3'd1, 4'h0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0};
    vecs[5]  = {3'd2, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0, 1'b0};
    vecs[6]  = {3'd3, 4'hC, 4'hA, 1'b1, 4'hE, 1'b0, 1'b0};
    vecs[7]  = {3'd4, 4'hC, 4'hA, 1'b1, 4'h6, 1'b0, 1'b0};
    vecs[8]  = {3'd5, 4'hC, 4'hA, 1'b1, 4'h3, 1'b0, 1'b0};
    vecs[9]  = {3'd6, 4'h9, 4'h0, 1'b1, 4'h3, 1'b1, 1'b0};
    vecs[10] = {3'd7, 4'h9, 4'h0, 1'b0, 4'h4, 1'b1, 1'b0};
    vecs[11] = {3'd0, 4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1};
    vecs[12] = {3'd1, 4'h5, 4'h3, 1'b1, 4'h2, 1'b1, 1'b0};
    vecs[13] = {3'd6, 4'h4, 4'h0, 1'b0, 4'h8, 1'b0, 1'b0};
    vecs[14] = {3'd7, 4'h2, 4'h5, 1'b1, 4'h9, 1'b0, 1'b0};

    // Reset held with nonzero inputs: outputs must stay cleared.
    drive(3'd0, 4'hF, 4'hF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", {bus.CarryOUT, bus.Y, bus.overflow}, 6'b000000);

    @(negedge clk);
    rst = 1'b0;

    // Directed vectors back to back, one per cycle.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      chk($sformatf("model_vec%0d", i),
          model(int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].cin), int'(vecs[i].op)),
          {vecs[i].c, vecs[i].y, vecs[i].v});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {bus.CarryOUT, bus.Y, bus.overflow},
          {vecs[i].c, vecs[i].y, vecs[i].v});
    end

    // Random operations, changing every cycle.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(3'($urandom_range(7, 0)), 4'($urandom_range(15, 0)),
            4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
    end

    // Mid-run asynchronous reset: outputs clear without a clock edge.
    @(negedge clk);
    drive(3'd0, 4'hF, 4'hF, 1'b1);
    @(posedge clk);
    #1;
    chk("pre_async_rst", {bus.CarryOUT, bus.Y, bus.overflow}, 6'b111110);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {bus.CarryOUT, bus.Y, bus.overflow}, 6'b000000);
    @(negedge clk);
    #1;
    rst = 1'b0;
    drive(3'd1, 4'h7, 4'hF, 1'b1);
    #1;
    chk("rst_released_no_edge", {bus.CarryOUT, bus.Y, bus.overflow}, 6'b000000);
    @(posedge clk);
    #1;
    chk("first_after_rst", {bus.CarryOUT, bus.Y, bus.overflow}, 6'b010001);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(3'(i % 8), 4'($urandom_range(15, 0)),
            4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
